// File: rtl/spram_line_writer_if.sv
// ============================================================================
// Module   : spram_line_writer_if
// Summary  : Stream, RAM write port and buffer-status bundle for spram_line_writer.
// Options  : SPRAM_LINE_WR_BYTE_MASK_EN adds the s_keep byte mask.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spram_line_writer_if #(
    parameter int c_ADDR_WIDTH = 10,
    parameter int c_DATA_WIDTH = 32,
    parameter int c_BE_WIDTH   = 4
);
    logic                    s_valid;
    logic                    s_ready;
    logic [c_DATA_WIDTH-1:0] s_data;
    logic                    s_last;
`ifdef SPRAM_LINE_WR_BYTE_MASK_EN
    logic [c_BE_WIDTH-1:0]   s_keep;
`endif
    logic [c_ADDR_WIDTH-1:0] ram_addr;
    logic [c_DATA_WIDTH-1:0] ram_wr_data;
    logic                    ram_wr_en;
    logic [c_BE_WIDTH-1:0]   ram_wr_byte_en;
    logic                    buf_full;
    logic [c_ADDR_WIDTH:0]   buf_len;
    logic                    buf_trunc;
    logic                    buf_release;

    // master: capture front end plus buffer reader
    modport master (
        output s_valid, s_data, s_last, buf_release,
`ifdef SPRAM_LINE_WR_BYTE_MASK_EN
        output s_keep,
`endif
        input  s_ready, ram_addr, ram_wr_data, ram_wr_en, ram_wr_byte_en,
        input  buf_full, buf_len, buf_trunc
    );

    modport slave (
        input  s_valid, s_data, s_last, buf_release,
`ifdef SPRAM_LINE_WR_BYTE_MASK_EN
        input  s_keep,
`endif
        output s_ready, ram_addr, ram_wr_data, ram_wr_en, ram_wr_byte_en,
        output buf_full, buf_len, buf_trunc
    );
endinterface

`default_nettype wire

// File: rtl/spram_line_writer.sv
// ============================================================================
// Module   : spram_line_writer
// Summary  : Writes one valid/ready video line into a single-port RAM from
//            address 0, then holds it as a full buffer until released.
// Options  : SPRAM_LINE_WR_BYTE_MASK_EN drives ram_wr_byte_en from s_keep.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spram_line_writer #(
    parameter int c_ADDR_WIDTH = 10,
    parameter int c_DATA_WIDTH = 32,
    parameter int c_BE_WIDTH   = 4,
    parameter int c_LINE_LEN   = 640
) (
    input wire                 clk,
    input wire                 rst,
    spram_line_writer_if.slave bus
);

    localparam logic [c_ADDR_WIDTH:0]   c_CNT_LAST = (c_ADDR_WIDTH+1)'(c_LINE_LEN - 1);
    localparam logic [c_ADDR_WIDTH:0]   c_CNT_MAX  = (c_ADDR_WIDTH+1)'(c_LINE_LEN);
    localparam logic [c_ADDR_WIDTH:0]   c_CNT_INC  = (c_ADDR_WIDTH+1)'(1);
    localparam logic [c_ADDR_WIDTH-1:0] c_PTR_INC  = (c_ADDR_WIDTH)'(1);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                  state_q,  state_d;
    logic [c_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ADDR_WIDTH:0]   wr_cnt_q, wr_cnt_d;
    logic                    wr_en_q,  wr_en_d;
    logic [c_ADDR_WIDTH-1:0] addr_q,   addr_d;
    logic [c_DATA_WIDTH-1:0] data_q,   data_d;
    logic [c_BE_WIDTH-1:0]   be_q,     be_d;
    logic                    trunc_q,  trunc_d;

    logic                    w_ready;
    logic                    w_xfer;
    logic [c_BE_WIDTH-1:0]   w_keep;

`ifdef SPRAM_LINE_WR_BYTE_MASK_EN
    assign w_keep = bus.s_keep;
`else
    localparam logic [c_BE_WIDTH-1:0] c_BE_ALL = '1;
    assign w_keep = c_BE_ALL;
`endif

    // Ready depends only on the registered state, never on s_valid.
    assign w_ready = (state_q == ST_FILL);
    assign w_xfer  = bus.s_valid & w_ready;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        wr_cnt_d = wr_cnt_q;
        wr_en_d  = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        be_d     = '0;
        trunc_d  = trunc_q;

        case (state_q)
            ST_FILL: begin
                if (w_xfer) begin
                    wr_en_d  = 1'b1;
                    addr_d   = wr_ptr_q;
                    data_d   = bus.s_data;
                    be_d     = w_keep;
                    wr_ptr_d = wr_ptr_q + c_PTR_INC;
                    wr_cnt_d = wr_cnt_q + c_CNT_INC;
                    // s_last on the final allowed word is a clean line, not a truncation.
                    if (bus.s_last) begin
                        state_d = ST_DRAIN;
                        trunc_d = 1'b0;
                    end else if (wr_cnt_q == c_CNT_LAST) begin
                        state_d = ST_DRAIN;
                        trunc_d = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                state_d = ST_FULL;
            end
            ST_FULL: begin
                if (bus.buf_release) begin
                    state_d  = ST_FILL;
                    wr_ptr_d = '0;
                    wr_cnt_d = '0;
                    trunc_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_FILL;
            wr_ptr_q <= '0;
            wr_cnt_q <= '0;
            wr_en_q  <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            be_q     <= '0;
            trunc_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            wr_cnt_q <= wr_cnt_d;
            wr_en_q  <= wr_en_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            be_q     <= be_d;
            trunc_q  <= trunc_d;
        end
    end

    assign bus.s_ready        = w_ready;
    assign bus.ram_addr       = addr_q;
    assign bus.ram_wr_data    = data_q;
    assign bus.ram_wr_en      = wr_en_q;
    assign bus.ram_wr_byte_en = be_q;
    assign bus.buf_full       = (state_q == ST_FULL);
    assign bus.buf_len        = (state_q == ST_FULL) ? wr_cnt_q : '0;
    assign bus.buf_trunc      = trunc_q;

    a_no_write_when_full: assert property (@(posedge clk) disable iff (rst)
        (state_q == ST_FULL) |-> !wr_en_q);

    a_cnt_in_range: assert property (@(posedge clk) disable iff (rst)
        wr_cnt_q <= c_CNT_MAX);

endmodule

`default_nettype wire
